multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_ctrl_pkg.sv | 46 ++++
 rtl/alu_decoder.sv | 23 ++
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode/funct constants, ALU encodings and FSM states
// Purpose: shared definitions for the multicycle MIPS controller.
// Ports: none (package).
package mips_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_ERROR    = 4'd13
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct field to 3-bit ALU control decode
// Purpose: combinational decode of the R-type funct field.
// Ports: i_funct (6) funct field in; o_alu (3) ALU control out.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu
);

  always_comb begin
    o_alu = ALU_ADD;  // unknown funct codes fall back to ADD
    case (i_funct)
      FN_ADD:  o_alu = ALU_ADD;
      FN_SUB:  o_alu = ALU_SUB;
      FN_AND:  o_alu = ALU_AND;
      FN_OR:   o_alu = ALU_OR;
      FN_SLT:  o_alu = ALU_SLT;
      default: o_alu = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control FSM with memory wait timeout
// Purpose: Moore control FSM for a multicycle MIPS datapath. Memory states wait
//   on mem_ready; MEM_TIMEOUT consecutive not-ready cycles trap into ERROR.
// Optional feature: define MCU_HALT_EN to make opcode 0x0C enter HALT;
//   otherwise 0x0C is illegal and halted is tied low.
// Ports:
//   clk, reset (async, active high)
//   instr[31:0], zero, mem_ready            - inputs
//   mem_read, mem_write, iord, ir_write     - memory controls
//   pc_write, branch, mem_to_reg, reg_dst, reg_write, alu_src_a,
//   alu_src_b[1:0], pc_src[1:0], alucontrol[ALU_W-1:0] - datapath controls
//   halted, error, illegal_op, state_o[3:0] - status
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_W       = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [ALU_W-1:0] alucontrol,
  output logic             halted,
  output logic             error,
  output logic             illegal_op,
  output logic [3:0]       state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [5:0]       w_opcode;
  logic [2:0]       w_funct_alu;
  logic [2:0]       w_alu;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_unused_instr;

  assign w_opcode       = instr[31:26];
  assign w_unused_instr = ^instr[25:6];

  alu_decoder u_alu_decoder (
    .i_funct (instr[5:0]),
    .o_alu   (w_funct_alu)
  );

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // Fires on the MEM_TIMEOUT-th consecutive not-ready cycle; mem_ready overrides it.
  assign w_timeout   = !mem_ready && (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      // Any state change clears the counter, which covers every entry into a wait state.
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_mem_state && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    w_alu      = 3'b000;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        w_alu     = ALU_ADD;
        if (mem_ready) begin
          // Gated with reset so the pulse stays low while reset holds the FSM in FETCH.
          ir_write = !reset;
          pc_write = !reset;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        w_alu     = ALU_ADD;
        case (w_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPE_EX;
          OP_BEQ:       w_next = S_BEQ;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_J:         w_next = S_JUMP;
`ifdef MCU_HALT_EN
          OP_HALT:      w_next = S_HALT;
`endif
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_alu     = ALU_ADD;
        w_next    = (w_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        w_alu     = w_funct_alu;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        w_alu     = ALU_SUB;
        branch    = 1'b1;
        pc_src    = 2'b01;
        pc_write  = zero;
        w_next    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_alu     = ALU_ADD;
        w_next    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_ERROR;
    endcase
  end

  assign alucontrol = ALU_W'(w_alu);
  assign error      = (r_state == S_ERROR);
  assign state_o    = r_state;

`ifdef MCU_HALT_EN
  assign halted = (r_state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, iord, ir_write;
  logic        pc_write, branch, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alucontrol;
  logic        halted, error, illegal_op;
  logic [3:0]  state_o;

  int n_total = 0;
  int n_bad   = 0;

  // {mem_read,mem_write,iord,ir_write}, {pc_write,branch,mem_to_reg,reg_dst,reg_write,alu_src_a},
  // alu_src_b, pc_src, alucontrol
  logic [16:0] ctl;
  logic [2:0]  st;
  assign ctl = {mem_read, mem_write, iord, ir_write,
                pc_write, branch, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, pc_src, alucontrol};
  assign st  = {halted, error, illegal_op};

  localparam logic [16:0] C_FETCH_WAIT = {4'b1000, 6'b000000, 2'b01, 2'b00, 3'b010};
  localparam logic [16:0] C_FETCH_GO   = {4'b1001, 6'b100000, 2'b01, 2'b00, 3'b010};
  localparam logic [16:0] C_DECODE     = {4'b0000, 6'b000000, 2'b11, 2'b00, 3'b010};
  localparam logic [16:0] C_MEMADR     = {4'b0000, 6'b000001, 2'b10, 2'b00, 3'b010};
  localparam logic [16:0] C_MEMRD      = {4'b1010, 6'b000000, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] C_MEMWB      = {4'b0000, 6'b001010, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] C_MEMWR      = {4'b0110, 6'b000000, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] C_ALUWB      = {4'b0000, 6'b000110, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] C_BEQ_T      = {4'b0000, 6'b110001, 2'b00, 2'b01, 3'b110};
  localparam logic [16:0] C_BEQ_N      = {4'b0000, 6'b010001, 2'b00, 2'b01, 3'b110};
  localparam logic [16:0] C_ADDI_WB    = {4'b0000, 6'b000010, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] C_JUMP       = {4'b0000, 6'b100000, 2'b00, 2'b10, 3'b000};

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alucontrol (alucontrol),
    .halted     (halted),
    .error      (error),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  // Cycles from a FETCH with mem_ready high until FETCH is reached again.
  task automatic lat(input string tag, input logic [31:0] ins, input int exp);
    int n;
    instr     = ins;
    mem_ready = 1'b1;
    cyc();
    n = 1;
    while (state_o != 4'd0 && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, n, exp);
  endtask

  logic [5:0] fn_tab  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
  logic [2:0] alu_tab [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

  initial begin
    reset = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_state", state_o, 4'd0);
    chk("rst_ctl", ctl, C_FETCH_WAIT);
    chk("rst_status", st, 3'b000);
    cyc();
    reset = 1'b0;
    #1;

    // add walk-through
    instr = 32'h012A4020; mem_ready = 1'b1; #1;
    chk("add_fetch", ctl, C_FETCH_GO);
    cyc(); chk("add_dec_st", state_o, 4'd1); chk("add_dec_ctl", ctl, C_DECODE);
    cyc(); chk("add_ex_st", state_o, 4'd6);
    chk("add_ex_ctl", ctl, {4'b0000, 6'b000001, 2'b00, 2'b00, 3'b010});
    cyc(); chk("add_wb_ctl", ctl, C_ALUWB);
    cyc(); chk("add_back", state_o, 4'd0);

    // funct decode table
    for (int i = 0; i < 6; i++) begin
      instr = {26'h0000000, fn_tab[i]};
      cyc(); cyc();
      chk($sformatf("funct_%0h", fn_tab[i]), alucontrol, alu_tab[i]);
      cyc(); cyc();
    end

    // latencies with mem_ready high
    lat("lat_lw",   32'h8D090004, 5);
    lat("lat_sw",   32'hAD090004, 4);
    lat("lat_add",  32'h012A4020, 4);
    lat("lat_addi", 32'h21090005, 4);
    lat("lat_beq",  32'h11090003, 3);
    lat("lat_j",    32'h08000010, 3);

    // lw with three wait cycles in MEMRD
    instr = 32'h8D090004; mem_ready = 1'b1;
    cyc(); cyc();
    chk("lw_memadr", ctl, C_MEMADR);
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lw_wait%0d", i), {state_o, ctl}, {4'd3, C_MEMRD});
      cyc();
    end
    mem_ready = 1'b1; #1;
    chk("lw_rd_last", {state_o, ctl}, {4'd3, C_MEMRD});
    cyc(); chk("lw_wb", {state_o, ctl}, {4'd4, C_MEMWB});
    cyc();

    // sw, beq taken / not taken, addi, jump
    instr = 32'hAD090004;
    cyc(); cyc(); cyc();
    chk("sw_memwr", {state_o, ctl}, {4'd5, C_MEMWR});
    cyc();
    instr = 32'h11090003; zero = 1'b1;
    cyc(); cyc(); chk("beq_taken", {state_o, ctl}, {4'd8, C_BEQ_T});
    cyc();
    zero = 1'b0;
    cyc(); cyc(); chk("beq_not", ctl, C_BEQ_N);
    cyc();
    instr = 32'h21090005;
    cyc(); cyc(); chk("addi_ex", {state_o, ctl}, {4'd9, C_MEMADR});
    cyc(); chk("addi_wb", {state_o, ctl}, {4'd10, C_ADDI_WB});
    cyc();
    instr = 32'h08000010;
    cyc(); cyc(); chk("jump", {state_o, ctl}, {4'd11, C_JUMP});
    cyc();

    // illegal opcode
    instr = 32'hFC000000;
    cyc(); chk("ill_pulse", st, 3'b001);
    cyc(); chk("ill_back", {state_o, 1'b0, st}, {4'd0, 4'b0000});

    // syscall / halt opcode
    instr = 32'h30000000;
    cyc();
`ifdef MCU_HALT_EN
    cyc(); cyc(); cyc();
    chk("halt_hold", {state_o, ctl, st}, {4'd12, 17'h0, 3'b100});
    do_reset();
    chk("halt_reset", state_o, 4'd0);
`else
    chk("sys_illegal", st, 3'b001);
    cyc();
    chk("sys_back", {state_o, st}, {4'd0, 3'b000});
`endif

    // mem_ready on the would-be timeout cycle wins
    instr = 32'h21090005; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    chk("win_wait", state_o, 4'd0);
    mem_ready = 1'b1;
    cyc(); chk("win_decode", state_o, 4'd1);
    cyc(); cyc(); cyc();

    // timeout in FETCH
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    chk("to_15", state_o, 4'd0);
    cyc();
    chk("to_err", {state_o, ctl, st}, {4'd13, 17'h0, 3'b010});
    mem_ready = 1'b1;
    cyc(); chk("to_sticky", state_o, 4'd13);
    reset = 1'b1; #1;
    chk("to_async_rst", {state_o, st}, {4'd0, 3'b000});
    cyc(); reset = 1'b0; #1;

    // reset while stalled in MEMWR
    instr = 32'hAD090004; mem_ready = 1'b1;
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc(); cyc();
    chk("wr_stall", {state_o, mem_write}, {4'd5, 1'b1});
    reset = 1'b1; #1;
    chk("wr_rst", {state_o, ctl}, {4'd0, C_FETCH_WAIT});
    cyc(); reset = 1'b0; #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
